// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - shared register-file constants for the read unit
package reg_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NREG     = 2**ADDR_W;
    localparam int ZERO_REG = 0;
endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-write scoreboard with same-cycle write forgiveness
module reg_scoreboard import reg_pkg::*; #(
    parameter int ADDR_W = reg_pkg::ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic                 set_en,
    input  logic [ADDR_W-1:0]    set_addr,
    input  logic [ADDR_W-1:0]    rs_addr,
    input  logic [ADDR_W-1:0]    rt_addr,
    input  logic                 dest_en,
    input  logic [ADDR_W-1:0]    dest_addr,
    output logic [2**ADDR_W-1:0] pending,
    output logic                 hazard
);
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

    logic [2**ADDR_W-1:0] pending_nxt;
    logic                 rs_busy;
    logic                 rt_busy;
    logic                 dest_busy;

    // A write landing this cycle retires its pending bit, so it cannot stall a reader.
    always_comb begin
        rs_busy   = (rs_addr != ZERO) && pending[rs_addr] && !(wr_en && wr_addr == rs_addr);
        rt_busy   = (rt_addr != ZERO) && pending[rt_addr] && !(wr_en && wr_addr == rt_addr);
        dest_busy = dest_en && (dest_addr != ZERO) && pending[dest_addr]
                    && !(wr_en && wr_addr == dest_addr);
        hazard    = rs_busy || rt_busy || dest_busy;
    end

    // Set is applied after clear so a same-cycle set/clear of one bit leaves it set.
    always_comb begin
        pending_nxt = pending;
        if (wr_en && wr_addr != ZERO) begin
            pending_nxt[wr_addr] = 1'b0;
        end
        if (set_en && set_addr != ZERO) begin
            pending_nxt[set_addr] = 1'b1;
        end
        pending_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end
endmodule

// File: rtl/reg_read_unit.sv
// rtl/reg_read_unit.sv - operand read with write bypass, hazard stall and one-deep response register
module reg_read_unit import reg_pkg::*; #(
    parameter int DATA_W = reg_pkg::DATA_W,
    parameter int ADDR_W = reg_pkg::ADDR_W
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic [(2**ADDR_W)*DATA_W-1:0] RegsFlat,
    input  logic                          WrEn,
    input  logic [ADDR_W-1:0]             WrAddr,
    input  logic [DATA_W-1:0]             WrData,
    input  logic                          ReqValid,
    output logic                          ReqReady,
    input  logic [ADDR_W-1:0]             RsAddr,
    input  logic [ADDR_W-1:0]             RtAddr,
    input  logic                          DestEn,
    input  logic [ADDR_W-1:0]             DestAddr,
    output logic                          RspValid,
    input  logic                          RspReady,
    output logic [DATA_W-1:0]             RsData,
    output logic [DATA_W-1:0]             RtData,
    output logic [2**ADDR_W-1:0]          Pending
);
    logic              hazard;
    logic              accept;
    logic [DATA_W-1:0] rs_sel;
    logic [DATA_W-1:0] rt_sel;

    function automatic logic [DATA_W-1:0] operand(
        input logic [ADDR_W-1:0]             addr,
        input logic                          wr_en,
        input logic [ADDR_W-1:0]             wr_addr,
        input logic [DATA_W-1:0]             wr_data,
        input logic [(2**ADDR_W)*DATA_W-1:0] regs
    );
        if (addr == ADDR_W'(ZERO_REG)) begin
            return '0;
        end
        if (wr_en && wr_addr == addr) begin
            return wr_data;
        end
        return regs[int'(addr)*DATA_W +: DATA_W];
    endfunction

    reg_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .clk       (Clock),
        .reset     (Reset),
        .wr_en     (WrEn),
        .wr_addr   (WrAddr),
        .set_en    (accept && DestEn),
        .set_addr  (DestAddr),
        .rs_addr   (RsAddr),
        .rt_addr   (RtAddr),
        .dest_en   (DestEn),
        .dest_addr (DestAddr),
        .pending   (Pending),
        .hazard    (hazard)
    );

    always_comb begin
        ReqReady = (!RspValid || RspReady) && !hazard && !Reset;
        accept   = ReqValid && ReqReady;
        rs_sel   = operand(RsAddr, WrEn, WrAddr, WrData, RegsFlat);
        rt_sel   = operand(RtAddr, WrEn, WrAddr, WrData, RegsFlat);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            RspValid <= 1'b0;
            RsData   <= '0;
            RtData   <= '0;
        end else if (accept) begin
            RspValid <= 1'b1;
            RsData   <= rs_sel;
            RtData   <= rt_sel;
        end else if (RspReady) begin
            RspValid <= 1'b0;
        end
    end
endmodule

// File: doc/reg_read_unit.md
REG_READ_UNIT -- requirements
Module: reg_read_unit

Interface
REQ-001 Parameter DATA_W, default 32: register data width in bits.
REQ-002 Parameter ADDR_W, default 5: register address width; NREG = 2**ADDR_W = 32.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named Clock and Reset.
REQ-004 Clock  in  1  rising-edge clock.
REQ-005 Reset  in  1  synchronous active-high reset.
REQ-006 RegsFlat  in  NREG*DATA_W  all register-file outputs; register k occupies bits [k*DATA_W +: DATA_W].
REQ-007 WrEn  in  1  register-file write strobe for this cycle.
REQ-008 WrAddr  in  ADDR_W  register-file write address.
REQ-009 WrData  in  DATA_W  register-file write data.
REQ-010 ReqValid  in  1  read request valid.
REQ-011 ReqReady  out  1  read request accepted when high together with ReqValid.
REQ-012 RsAddr, RtAddr  in  ADDR_W each  source register addresses.
REQ-013 DestEn  in  1  request will produce a result for DestAddr.
REQ-014 DestAddr  in  ADDR_W  destination register of the request.
REQ-015 RspValid  out  1  response valid.
REQ-016 RspReady  in  1  consumer accepts the response.
REQ-017 RsData, RtData  out  DATA_W each  read operand data.
REQ-018 Pending  out  NREG  scoreboard contents, bit k = register k has a write outstanding.

Function
REQ-019 Register 0 SHALL always read as 0, SHALL never be marked pending, and SHALL never cause a hazard.
REQ-020 Operand selection SHALL be: 0 if addr==0; else WrData if WrEn and WrAddr==addr (bypass); else the RegsFlat slice.
REQ-021 A hazard SHALL exist when a nonzero RsAddr, RtAddr, or (with DestEn) DestAddr has its Pending bit set and that bit is not being cleared by a write to the same address in the same cycle.
REQ-022 ReqReady SHALL equal (!RspValid || RspReady) && !hazard && !Reset; it is combinational from the request inputs.
REQ-023 On acceptance, RsData/RtData SHALL be registered and RspValid SHALL be set on the next edge (latency 1 cycle).
REQ-024 RspValid and the data SHALL hold stable while RspValid && !RspReady; back-to-back accepts SHALL sustain one response per cycle.
REQ-025 If RspReady && RspValid with no new accept, RspValid SHALL clear on the next edge.
REQ-026 Each edge, Pending[WrAddr] SHALL clear when WrEn is high and WrAddr != 0.
REQ-027 Each edge, on acceptance with DestEn and DestAddr != 0, Pending[DestAddr] SHALL be set; a simultaneous set and clear of the same bit SHALL leave it set.
REQ-028 A request whose sources are being written this cycle SHALL be accepted using the bypass value and SHALL NOT stall.

Reset
REQ-029 While Reset is high at an edge: Pending=0, RspValid=0, RsData=0, RtData=0; an un-consumed response SHALL be discarded.
REQ-030 ReqReady SHALL be 0 in any cycle in which Reset is high.

Structure
REQ-031 DATA_W, ADDR_W, NREG and the ZERO_REG=0 constant SHALL live in the shared package reg_pkg.
REQ-032 The scoreboard (set/clear/lookup, REQ-021/026/027) SHALL be the sub-module reg_scoreboard; operand select and the output register SHALL live in reg_read_unit.

Verification
REQ-033 Reset, then reg5=0x1234 in RegsFlat, request Rs=5 Rt=0 -> RspValid next cycle, RsData=0x1234, RtData=0, Pending=0.
REQ-034 Request Dest=7 accepted; next request Rs=7 -> ReqReady=0 until WrEn WrAddr=7 WrData=0xCAFE; in that cycle the request is accepted and RsData=0xCAFE; afterwards Pending[7]=0.
REQ-035 RspReady held low for 3 cycles with ReqValid high -> RspValid stays 1, data stable, ReqReady=0; RspReady=1 -> next request accepted the same cycle.
REQ-036 A write to reg 9 and an accepted request with Dest=9 in the same cycle -> Pending[9]=1; a request with Dest=0 -> Pending unchanged; WrAddr=0 WrData=0xFFFF -> a read of reg 0 returns 0.
REQ-037 Pending[3]=1 and RspValid=1 held, then Reset for one cycle -> Pending=0, RspValid=0, data=0; a Rs=3 request is accepted on the first cycle after reset.
